imem_dmem_arbiter: RTL and testbench

- Sequences one shared single-port memory between the pipeline's instruction-fetch (IF) port and data-memory (MEM-stage) port.
- Grants one requester at a time and drives the memory with a fixed access latency.
- Returns read data with a one-cycle ready pulse; raises per-stage stall signals so the pipeline freezes until its access completes.
- Sits beside the hazard-detection unit; its stalls OR into the pipeline stall/flush network.

---
 rtl/imem_dmem_arbiter_if.sv | 40 ++++
 rtl/imem_dmem_arbiter.sv | 124 ++++++++++++
 tb/tb_imem_dmem_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_dmem_arbiter_if.sv
// Bus bundle between the pipeline (IF and MEM stages), the shared memory and
// the arbiter. slave = the arbiter's view; master = the pipeline/memory view.
interface imem_dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // instruction fetch side
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_flush;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          stall_if;
  // data side
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ready;
  logic          stall_mem;
  // shared memory side
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ready, stall_if, dm_rdata, dm_ready, stall_mem,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ready, stall_if, dm_rdata, dm_ready, stall_mem,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port memory between instruction fetch and the MEM stage.
// Data wins ties, but after MAX_DSTREAK data grants with IF waiting, IF is
// forced through so fetch never starves. Each access is a fixed MEM_LAT cycles
// followed by a one-cycle response, then back to IDLE for the next arbitration.
module imem_dmem_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MEM_LAT     = 2,
  parameter int MAX_DSTREAK = 2
) (
  input logic              clk,
  input logic              rst_n,
  imem_dmem_arbiter_if.slave bus
);
  localparam int DSW = $clog2(MAX_DSTREAK + 2);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

  state_t         state;
  owner_t         owner;
  logic [3:0]     cnt;
  logic [DSW-1:0] dstreak;
  logic           kill;
  logic           acc_we;
  logic           if_rdy_q, dm_rdy_q;
  logic           mem_en_q, mem_we_q;
  logic [AW-1:0]  mem_addr_q;
  logic [DW-1:0]  mem_wdata_q, if_rdata_q, dm_rdata_q;

  logic if_want, ds_ok, grant_dm, grant_if;

  // A flushed fetch is not a live request, so it neither wins nor blocks data.
  assign if_want  = bus.if_req & ~bus.if_flush;
  assign ds_ok    = dstreak < DSW'(MAX_DSTREAK);
  assign grant_dm = bus.dm_req & (~if_want | ds_ok);
  assign grant_if = ~grant_dm & if_want;

  // Arbitration, access sequencing and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= OWN_NONE;
      cnt         <= '0;
      dstreak     <= '0;
      kill        <= 1'b0;
      acc_we      <= 1'b0;
      if_rdy_q    <= 1'b0;
      dm_rdy_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          kill  <= 1'b0;
          owner <= OWN_NONE;
          if (!bus.if_req) dstreak <= '0;
          if (grant_dm) begin
            mem_addr_q  <= bus.dm_addr;
            mem_wdata_q <= bus.dm_wdata;
            mem_we_q    <= bus.dm_we;
            acc_we      <= bus.dm_we;
            mem_en_q    <= 1'b1;
            cnt         <= 4'(MEM_LAT);
            owner       <= OWN_DM;
            state       <= ACCESS;
            // saturates: ds_ok is false once the limit is reached
            if (bus.if_req && ds_ok) dstreak <= dstreak + DSW'(1);
          end else if (grant_if) begin
            mem_addr_q  <= bus.if_addr;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            acc_we      <= 1'b0;
            mem_en_q    <= 1'b1;
            cnt         <= 4'(MEM_LAT);
            owner       <= OWN_IF;
            dstreak     <= '0;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          cnt      <= cnt - 4'd1;
          if (owner == OWN_IF && bus.if_flush) kill <= 1'b1;
          if (cnt == 4'd1) begin
            state <= RESP;
            if (owner == OWN_DM) begin
              dm_rdy_q <= 1'b1;
              if (!acc_we) dm_rdata_q <= bus.mem_rdata;
            end else if (owner == OWN_IF && !kill && !bus.if_flush) begin
              if_rdy_q   <= 1'b1;
              if_rdata_q <= bus.mem_rdata;
            end
          end
        end
        RESP: begin
          if_rdy_q <= 1'b0;
          dm_rdy_q <= 1'b0;
          kill     <= 1'b0;
          owner    <= OWN_NONE;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A redirect arriving in the response cycle still hides the fetch result.
  assign bus.if_ready  = if_rdy_q & ~bus.if_flush;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_ready  = dm_rdy_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.stall_if  = bus.if_req & ~bus.if_ready & ~bus.if_flush;
  assign bus.stall_mem = bus.dm_req & ~bus.dm_ready;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Bench for imem_dmem_arbiter: a behavioural memory that only presents valid
// read data in the MEM_LAT-th access cycle, and a scoreboard of expected
// responses (port, data, cycle) checked whenever a ready pulse appears.
module tb_imem_dmem_arbiter;
  localparam int AW = 32, DW = 32, L = 2, MD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  imem_dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  imem_dmem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(L), .MAX_DSTREAK(MD)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // ---------------- memory model ----------------
  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C220004;
    return 32'hA5000000 | {8'h00, a[23:0]};
  endfunction

  logic [31:0] wr_mem [0:4095];
  bit          wr_vld [0:4095];
  int          ph_q = 0;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      ph_q <= 2;
      if (bus.mem_we) begin
        wr_mem[bus.mem_addr[13:2]] <= bus.mem_wdata;
        wr_vld[bus.mem_addr[13:2]] <= 1'b1;
      end
    end else if (ph_q != 0 && ph_q < 200) ph_q <= ph_q + 1;
  end

  always_comb begin
    bus.mem_rdata = 32'hBAD0BAD0;
    if ((bus.mem_en ? 1 : ph_q) == L)
      bus.mem_rdata = wr_vld[bus.mem_addr[13:2]] ? wr_mem[bus.mem_addr[13:2]]
                                                 : init_word(bus.mem_addr);
  end

  // ---------------- scoreboard ----------------
  typedef struct { bit is_if; logic [31:0] data; int when; } exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  logic [31:0] last_if = '0, last_dm = '0;

  task automatic push(input bit is_if, input logic [31:0] d, input int when);
    exp_t e;
    e.is_if = is_if; e.data = d; e.when = when;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && (bus.if_ready || bus.dm_ready)) begin
      if (sbq.size() == 0) chk("spurious_ready", {bus.if_ready, bus.dm_ready}, 0);
      else begin
        mon_e = sbq.pop_front();
        chk("resp_port", {bus.if_ready, bus.dm_ready}, mon_e.is_if ? 2'b10 : 2'b01);
        chk("resp_data", mon_e.is_if ? bus.if_rdata : bus.dm_rdata, mon_e.data);
        chk("resp_cycle", cyc, mon_e.when);
      end
    end
  end

  task automatic cyc_start(); @(posedge clk); #1; endtask
  task automatic mid(); @(negedge clk); endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_en"}, bus.mem_en, 0);
    chk({tag, "_mem_we"}, bus.mem_we, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_rdy"}, {bus.if_ready, bus.dm_ready}, 0);
    chk({tag, "_rdata"}, {bus.if_rdata, bus.dm_rdata}, 0);
  endtask

  int t0;

  initial begin
    bus.if_req = 0; bus.if_addr = '0; bus.if_flush = 0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0;
    repeat (2) mid();
    chk_zero("rst");
    cyc_start(); rst_n = 1'b1;
    repeat (2) cyc_start();

    // single IF read
    t0 = cyc; bus.if_addr = 32'h40; bus.if_req = 1;
    push(1, 32'h8C220004, t0 + L + 1);
    for (int n = 0; n <= L + 1; n++) begin
      if (n > 0) cyc_start();
      mid();
      chk("t1_mem_en", bus.mem_en, n == 1);
      chk("t1_stall_if", bus.stall_if, n <= L);
      if (n == 1) begin
        chk("t1_mem_addr", bus.mem_addr, 32'h40);
        chk("t1_mem_we", bus.mem_we, 0);
      end
    end
    bus.if_req = 0; last_if = 32'h8C220004;
    repeat (2) cyc_start();

    // simultaneous requests: data first, IF after dm_ready
    t0 = cyc;
    bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h1000;
    bus.if_req = 1; bus.if_addr = 32'h44;
    push(0, init_word(32'h1000), t0 + 3);
    push(1, init_word(32'h44), t0 + 7);
    for (int n = 0; n <= 7; n++) begin
      if (n > 0) cyc_start();
      mid();
      chk("t2_mem_en", bus.mem_en, n == 1 || n == 5);
      if (n == 1) chk("t2_addr_d", bus.mem_addr, 32'h1000);
      if (n == 5) chk("t2_addr_i", bus.mem_addr, 32'h44);
      chk("t2_stall_mem", bus.stall_mem, n < 3);
      if (n == 3) bus.dm_req = 0;
    end
    bus.if_req = 0;
    last_dm = init_word(32'h1000); last_if = init_word(32'h44);
    repeat (2) cyc_start();

    // continuous contention: D, D, I, D, D, I
    t0 = cyc;
    bus.dm_req = 1; bus.dm_addr = 32'h1004; bus.if_req = 1; bus.if_addr = 32'h48;
    for (int k = 0; k < 6; k++)
      if (k % 3 == 2) push(1, init_word(32'h48), t0 + 4 * k + 3);
      else            push(0, init_word(32'h1004), t0 + 4 * k + 3);
    for (int n = 0; n <= 23; n++) begin
      if (n > 0) cyc_start();
      mid();
      chk("t3_mem_en", bus.mem_en, n % 4 == 1);
      if (n % 4 == 1)
        chk("t3_grant_addr", bus.mem_addr, ((n / 4) % 3 == 2) ? 32'h48 : 32'h1004);
    end
    bus.dm_req = 0; bus.if_req = 0;
    last_dm = init_word(32'h1004); last_if = init_word(32'h48);
    repeat (2) cyc_start();

    // data write: dm_rdata must keep its previous value
    t0 = cyc;
    bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h2000; bus.dm_wdata = 32'hDEADBEEF;
    push(0, last_dm, t0 + 3);
    for (int n = 0; n <= 3; n++) begin
      if (n > 0) cyc_start();
      if (n == 1) bus.dm_wdata = 32'h0;
      mid();
      chk("t4_mem_en", bus.mem_en, n == 1);
      chk("t4_mem_we", bus.mem_we, n == 1);
      if (n == 1 || n == 2) begin
        chk("t4_wdata_held", bus.mem_wdata, 32'hDEADBEEF);
        chk("t4_addr_held", bus.mem_addr, 32'h2000);
      end
    end
    bus.dm_req = 0; bus.dm_we = 0;
    cyc_start();
    // read the written word back
    t0 = cyc; bus.dm_req = 1; bus.dm_addr = 32'h2000;
    push(0, 32'hDEADBEEF, t0 + 3);
    repeat (3) cyc_start();
    mid(); bus.dm_req = 0; last_dm = 32'hDEADBEEF;
    repeat (2) cyc_start();

    // IF flushed mid-access, then a redirected fetch
    t0 = cyc; bus.if_req = 1; bus.if_addr = 32'h80;
    for (int n = 0; n <= 7; n++) begin
      if (n == 2) begin cyc_start(); bus.if_flush = 1; bus.if_req = 0; end
      else if (n == 3) begin
        cyc_start(); bus.if_flush = 0; bus.if_req = 1; bus.if_addr = 32'hC0;
        push(1, init_word(32'hC0), t0 + 7);
      end else if (n > 0) cyc_start();
      mid();
      chk("t5_mem_en", bus.mem_en, n == 1 || n == 5);
      if (n == 2) chk("t5_stall_if", bus.stall_if, 0);
      if (n == 3) begin
        chk("t5_no_ready", bus.if_ready, 0);
        chk("t5_rdata_kept", bus.if_rdata, last_if);
      end
      if (n == 4) chk("t5_idle_stall", bus.stall_if, 1);
      if (n == 5) chk("t5_addr", bus.mem_addr, 32'hC0);
    end
    bus.if_req = 0; last_if = init_word(32'hC0);
    repeat (2) cyc_start();

    // async reset in the middle of an access
    bus.dm_req = 1; bus.dm_addr = 32'h1008;
    mid(); cyc_start(); mid();
    chk("t6_pre_en", bus.mem_en, 1);
    #1 rst_n = 1'b0;
    #1 chk_zero("t6_async");
    bus.dm_req = 0;
    repeat (2) cyc_start();
    rst_n = 1'b1;
    repeat (2) cyc_start();
    t0 = cyc; bus.if_req = 1; bus.if_addr = 32'h4C;
    push(1, init_word(32'h4C), t0 + L + 1);
    for (int n = 0; n <= L + 1; n++) begin
      if (n > 0) cyc_start();
      mid();
      chk("t6_mem_en", bus.mem_en, n == 1);
    end
    bus.if_req = 0;
    repeat (6) cyc_start();
    chk("sb_drain", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
